// File: rtl/dma_sched_pkg.sv
// Shared definitions for the DMA channel scheduler: one-hot state codes,
// descriptor alignment check and the default watchdog limit.
package dma_sched_pkg;

  localparam logic [6:0] ST_IDLE  = 7'b000_0001;
  localparam logic [6:0] ST_CHECK = 7'b000_0010;
  localparam logic [6:0] ST_START = 7'b000_0100;
  localparam logic [6:0] ST_WAIT  = 7'b000_1000;
  localparam logic [6:0] ST_DONE  = 7'b001_0000;
  localparam logic [6:0] ST_ERR   = 7'b010_0000;
  localparam logic [6:0] ST_HALT  = 7'b100_0000;

  localparam int DEFAULT_TIMEOUT = 65535;

  // Masters move whole 32-bit words, so addresses and length must be 4-byte multiples.
  function automatic logic desc_misaligned(input logic [1:0] src_lo,
                                           input logic [1:0] dst_lo,
                                           input logic [1:0] len_lo);
    return (src_lo | dst_lo | len_lo) != 2'b00;
  endfunction

endpackage

// File: rtl/dma_channel_scheduler_rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester at or after ptr,
// wrapping modulo NUM_CH.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic              grant_valid,
  output logic [PTR_W-1:0]  grant_idx
);

  // Scan from farthest to nearest so the nearest requester is written last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NUM_CH]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'((int'(ptr) + i) % NUM_CH);
      end
    end
  end

endmodule

// File: rtl/dma_channel_scheduler.sv
// Round-robin descriptor scheduler sharing one read/write DMA master pair.
// Optional watchdog + HALT state enabled by defining DMA_SCHED_TIMEOUT_EN.
module dma_channel_scheduler
  import dma_sched_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int LEN_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int PTR_W          = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            i_ch_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] i_ch_src_addr,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] i_ch_dst_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  i_ch_len,
  output logic [NUM_CH-1:0]            o_ch_ack,
  output logic [NUM_CH-1:0]            o_ch_done,
  output logic [NUM_CH-1:0]            o_ch_err,
  output logic                         o_rd_start,
  output logic                         o_wr_start,
  output logic [ADDR_WIDTH-1:0]        o_rd_src_addr,
  output logic [ADDR_WIDTH-1:0]        o_wr_dst_addr,
  output logic [LEN_WIDTH-1:0]         o_xfer_len,
  input  logic                         i_rd_done,
  input  logic                         i_wr_done,
  output logic                         o_busy,
  output logic [PTR_W-1:0]             o_active_ch
);

  logic [6:0]            state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      active_q, active_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  rd_seen_q, rd_seen_d, wr_seen_q, wr_seen_d;
  logic                  start_q, start_d, busy_q, busy_d;
  logic [NUM_CH-1:0]     ack_q, ack_d, done_q, done_d, err_q, err_d;
  logic                  grant_valid;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      next_ptr;
  logic                  rd_now, wr_now;
`ifdef DMA_SCHED_TIMEOUT_EN
  logic [31:0]           cnt_q, cnt_d;
`endif

  rr_arbiter #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_arb (
    .req         (i_ch_req),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign next_ptr = (active_q == PTR_W'(NUM_CH - 1)) ? '0 : active_q + 1'b1;
  assign rd_now   = rd_seen_q | i_rd_done;
  assign wr_now   = wr_seen_q | i_wr_done;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    active_d  = active_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    rd_seen_d = rd_seen_q;
    wr_seen_d = wr_seen_q;
    start_d   = 1'b0;
    ack_d     = '0;
    done_d    = '0;
    err_d     = '0;
`ifdef DMA_SCHED_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          src_d            = i_ch_src_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          dst_d            = i_ch_dst_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          len_d            = i_ch_len[grant_idx*LEN_WIDTH +: LEN_WIDTH];
          ack_d[grant_idx] = 1'b1;
          active_d         = grant_idx;
          state_d          = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (len_q == '0)
          state_d = ST_DONE;
        else if (desc_misaligned(src_q[1:0], dst_q[1:0], len_q[1:0]))
          state_d = ST_ERR;
        else
          state_d = ST_START;
      end
      ST_START: begin
        start_d   = 1'b1;
        rd_seen_d = 1'b0;
        wr_seen_d = 1'b0;
        state_d   = ST_WAIT;
`ifdef DMA_SCHED_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ST_WAIT: begin
        rd_seen_d = rd_now;
        wr_seen_d = wr_now;
        // Completion is committed on the edge that sees the later done, so
        // o_ch_done follows that pulse by exactly one cycle.
        if (rd_now && wr_now) begin
          done_d[active_q] = 1'b1;
          rr_ptr_d         = next_ptr;
          state_d          = ST_IDLE;
        end
`ifdef DMA_SCHED_TIMEOUT_EN
        else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          err_d[active_q] = 1'b1;
          state_d         = ST_HALT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      ST_DONE: begin
        done_d[active_q] = 1'b1;
        rr_ptr_d         = next_ptr;
        state_d          = ST_IDLE;
      end
      ST_ERR: begin
        err_d[active_q] = 1'b1;
        rr_ptr_d        = next_ptr;
        state_d         = ST_IDLE;
      end
`ifdef DMA_SCHED_TIMEOUT_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      active_q  <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      rd_seen_q <= 1'b0;
      wr_seen_q <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      active_q  <= active_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      rd_seen_q <= rd_seen_d;
      wr_seen_q <= wr_seen_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef DMA_SCHED_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign o_ch_ack      = ack_q;
  assign o_ch_done     = done_q;
  assign o_ch_err      = err_q;
  assign o_rd_start    = start_q;
  assign o_wr_start    = start_q;
  assign o_rd_src_addr = src_q;
  assign o_wr_dst_addr = dst_q;
  assign o_xfer_len    = len_q;
  assign o_busy        = busy_q;
  assign o_active_ch   = active_q;

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Directed self-checking bench for dma_channel_scheduler (4 channels).
module tb_dma_channel_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] src, dst, len;
  logic [3:0]   ack, done, err;
  logic         rd_start, wr_start, rd_done, wr_done, busy;
  logic [31:0]  rd_addr, wr_addr, xlen;
  logic [1:0]   active;

  int checks = 0;
  int errors = 0;

  dma_channel_scheduler #(
    .NUM_CH(4), .ADDR_WIDTH(32), .LEN_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .i_ch_req(req), .i_ch_src_addr(src), .i_ch_dst_addr(dst), .i_ch_len(len),
    .o_ch_ack(ack), .o_ch_done(done), .o_ch_err(err),
    .o_rd_start(rd_start), .o_wr_start(wr_start),
    .o_rd_src_addr(rd_addr), .o_wr_dst_addr(wr_addr), .o_xfer_len(xlen),
    .i_rd_done(rd_done), .i_wr_done(wr_done),
    .o_busy(busy), .o_active_ch(active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input int ch, input logic [31:0] s, input logic [31:0] d,
                          input logic [31:0] l);
    src[ch*32 +: 32] = s;
    dst[ch*32 +: 32] = d;
    len[ch*32 +: 32] = l;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; rd_done = 0; wr_done = 0;
    src = '0; dst = '0; len = '0;
    tick();
    checks++; if ({ack, done, err} !== 12'h000) begin errors++; $display("FAIL reset_pulses got %h want 000", {ack, done, err}); end
    checks++; if ({rd_start, wr_start, busy} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b want 000", {rd_start, wr_start, busy}); end
    checks++; if ({rd_addr, wr_addr, xlen, active} !== '0) begin errors++; $display("FAIL reset_data got %h/%h/%h/%0d want zeros", rd_addr, wr_addr, xlen, active); end
    reset = 1'b0;
    tick();
  endtask

  // ch1 normal transfer, rd_done at +20, wr_done at +40
  task automatic test_basic();
    set_desc(1, 32'h1000, 32'h2000, 32'd256);
    req = 4'b0010;
    tick();
    req = '0;
    checks++; if (ack !== 4'b0010 || active !== 2'd1) begin errors++; $display("FAIL basic_ack got ack=%b ch=%0d want 0010 ch=1", ack, active); end
    checks++; if (rd_addr !== 32'h1000 || wr_addr !== 32'h2000 || xlen !== 32'd256) begin errors++; $display("FAIL basic_desc got %h %h %h want 1000 2000 100", rd_addr, wr_addr, xlen); end
    tick();
    checks++; if (rd_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_check_cycle got start=%b busy=%b want 0 1", rd_start, busy); end
    tick();
    checks++; if (rd_start !== 1'b1 || wr_start !== 1'b1) begin errors++; $display("FAIL basic_start got %b%b want 11", rd_start, wr_start); end
    for (int c = 4; c <= 40; c++) begin
      rd_done = (c == 20);
      wr_done = (c == 40);
      tick();
      checks++;
      if (rd_addr !== 32'h1000 || wr_addr !== 32'h2000 || xlen !== 32'd256 || rd_start !== 1'b0) begin
        errors++; $display("FAIL basic_stable c=%0d got %h %h %h st=%b", c, rd_addr, wr_addr, xlen, rd_start);
      end
      checks++;
      if (done !== ((c == 40) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL basic_done c=%0d got %b", c, done); end
    end
    rd_done = 0; wr_done = 0;
    tick();
    checks++; if (done !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL basic_after got done=%b busy=%b want 0000 0", done, busy); end
  endtask

  // zero-length descriptors on ch0/2/3 finish every 3 cycles: grant order 0,2,3,0
  task automatic test_round_robin();
    int exp_tick [4] = '{1, 4, 7, 10};
    logic [3:0] exp_ack [4] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
    int n;
    do_reset();
    set_desc(0, 32'h0, 32'h0, 32'd0);
    set_desc(2, 32'h0, 32'h0, 32'd0);
    set_desc(3, 32'h0, 32'h0, 32'd0);
    req = 4'b1101;
    n = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if (n < 4 && t == exp_tick[n]) begin
        if (ack !== exp_ack[n]) begin errors++; $display("FAIL rr_grant t=%0d got %b want %b", t, ack, exp_ack[n]); end
        n++;
      end else if (ack !== 4'b0000) begin
        errors++; $display("FAIL rr_idle t=%0d got %b want 0000", t, ack);
      end
    end
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_zero_and_misaligned();
    set_desc(2, 32'h3000, 32'h4000, 32'd0);
    req = 4'b0100;
    tick();
    req = '0;
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL zlen_ack got %b want 0100", ack); end
    tick();
    checks++; if (done !== 4'b0000 || rd_start !== 1'b0) begin errors++; $display("FAIL zlen_mid got done=%b st=%b want 0000 0", done, rd_start); end
    tick();
    checks++; if (done !== 4'b0100 || rd_start !== 1'b0 || wr_start !== 1'b0) begin errors++; $display("FAIL zlen_done got done=%b st=%b%b want 0100 00", done, rd_start, wr_start); end
    tick();
    set_desc(0, 32'h100, 32'h200, 32'd6);
    req = 4'b0001;
    tick();
    req = '0;
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL mis_len_ack got %b want 0001", ack); end
    tick();
    tick();
    checks++; if (err !== 4'b0001 || done !== 4'b0000 || rd_start !== 1'b0) begin errors++; $display("FAIL mis_len_err got err=%b done=%b st=%b want 0001 0000 0", err, done, rd_start); end
    tick();
    checks++; if (err !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL mis_len_after got err=%b busy=%b", err, busy); end
    set_desc(3, 32'h1002, 32'h2000, 32'd8);
    req = 4'b1000;
    tick(); req = '0; tick(); tick();
    checks++; if (err !== 4'b1000 || rd_start !== 1'b0) begin errors++; $display("FAIL mis_src_err got err=%b st=%b want 1000 0", err, rd_start); end
    tick();
  endtask

  task automatic test_back_to_back_done();
    set_desc(0, 32'h40, 32'h80, 32'd16);
    req = 4'b0001;
    tick(); req = '0; tick(); tick();
    checks++; if (rd_start !== 1'b1) begin errors++; $display("FAIL same_start got %b want 1", rd_start); end
    rd_done = 1; wr_done = 1;
    tick();
    rd_done = 0; wr_done = 0;
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL same_done got %b want 0001", done); end
    tick();
    checks++; if (done !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL same_single got done=%b busy=%b want 0000 0", done, busy); end
    wr_done = 1;
    tick();
    wr_done = 0;
    tick();
    checks++; if ({done, err, rd_start, busy} !== 10'b0) begin errors++; $display("FAIL stray_idle got %b want 0", {done, err, rd_start, busy}); end
    // only rd_done this time: the stray wr_done must not count
    set_desc(1, 32'h500, 32'h600, 32'd4);
    req = 4'b0010;
    tick(); req = '0; tick(); tick();
    rd_done = 1;
    tick();
    rd_done = 0;
    for (int c = 0; c < 4; c++) tick();
    checks++; if (done !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL stray_nocount got done=%b busy=%b want 0000 1", done, busy); end
    wr_done = 1;
    tick();
    wr_done = 0;
    checks++; if (done !== 4'b0010) begin errors++; $display("FAIL rd_first_done got %b want 0010", done); end
    tick();
  endtask

  task automatic test_reset_mid();
    set_desc(2, 32'h700, 32'h800, 32'd8);
    req = 4'b0100;
    tick(); req = '0; tick(); tick();
    rd_done = 1; wr_done = 1;
    tick();
    rd_done = 0; wr_done = 0;
    tick();
    set_desc(3, 32'h900, 32'hA00, 32'd8);
    req = 4'b1000;
    tick(); req = '0; tick(); tick(); tick();
    checks++; if (busy !== 1'b1 || active !== 2'd3) begin errors++; $display("FAIL mid_inwait got busy=%b ch=%0d want 1 3", busy, active); end
    reset = 1'b1;
    #1;
    checks++; if ({busy, rd_start, active, ack, done, err} !== '0 || {rd_addr, wr_addr, xlen} !== '0) begin
      errors++; $display("FAIL mid_reset got busy=%b ch=%0d addr=%h/%h len=%h", busy, active, rd_addr, wr_addr, xlen);
    end
    tick();
    reset = 1'b0;
    set_desc(1, 32'h10, 32'h20, 32'd0);
    req = 4'b1010;
    tick();
    req = '0;
    checks++; if (ack !== 4'b0010 || active !== 2'd1) begin errors++; $display("FAIL mid_ptr0 got ack=%b ch=%0d want 0010 1", ack, active); end
    tick(); tick(); tick();
  endtask

`ifdef DMA_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    set_desc(2, 32'h100, 32'h200, 32'd64);
    req = 4'b0100;
    tick(); req = '0; tick(); tick();
    checks++; if (rd_start !== 1'b1) begin errors++; $display("FAIL to_start got %b want 1", rd_start); end
    rd_done = 1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      rd_done = 0;
      checks++;
      if (err !== ((c == 16) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL to_err c=%0d got %b", c, err); end
    end
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || ack !== 4'b0000 || err !== 4'b0000) begin errors++; $display("FAIL to_halt c=%0d busy=%b ack=%b err=%b", c, busy, ack, err); end
    end
    req = '0;
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_zero_and_misaligned();
    test_back_to_back_done();
    test_reset_mid();
`ifdef DMA_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
